// File: rtl/cpack_ts_sequencer_if.sv
// Sample-set input stream and packed-word output stream of the timestamped channel packer.
// The sequencer takes the slave side; the ADC source / DMA sink take the master side.
interface cpack_ts_sequencer_if;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sop, out_eop
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sop, out_eop
  );
endinterface

// File: rtl/cpack_ts_sequencer.sv
// Packet sequencer: one timestamp word per packet, then enabled 16-bit channel samples
// from consecutive sample sets packed densely into 64-bit words, lowest channel first.
module cpack_ts_sequencer #(
  parameter int PKT_SAMPLES = 16,
  parameter int TS_W        = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            enable,
  cpack_ts_sequencer_if.slave   bus,
  output logic                  cfg_err,
  output logic [TS_W-1:0]       sample_count
);
  localparam int SET_W = $clog2(PKT_SAMPLES);

  typedef enum logic {IDLE, DATA} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        idx_reg [4];
  logic [1:0]        idx_next [4];
  logic [2:0]        n_reg;
  logic [2:0]        n_next;
  logic [2:0]        en_cnt;
  logic              mask_ok;
  logic [1:0]        fill_reg;
  logic [SET_W-1:0]  set_cnt_reg;
  logic [15:0]       acc_reg [3];
  logic [63:0]       out_data_reg;
  logic              out_valid_reg;
  logic              out_sop_reg;
  logic              out_eop_reg;
  logic [TS_W-1:0]   sample_count_reg;
  logic              cfg_err_reg;

  logic              out_free;
  logic              in_ready_c;
  logic              in_fire;
  logic              load_ts;
  logic              last_set;
  logic              word_done;
  logic [2:0]        fill_sum;
  logic [15:0]       samp [4];
  logic [15:0]       lane [4];

  // Ordered list of enabled channel indices; entries past the popcount are don't-care.
  always_comb begin
    en_cnt = 3'd0;
    for (int b = 0; b < 4; b++) begin
      idx_next[b] = 2'd0;
    end
    for (int b = 0; b < 4; b++) begin
      if (enable[b]) begin
        idx_next[en_cnt[1:0]] = 2'(b);
        en_cnt = en_cnt + 3'd1;
      end
    end
    n_next  = en_cnt;
    mask_ok = (en_cnt == 3'd1) || (en_cnt == 3'd2) || (en_cnt == 3'd4);
  end

  assign out_free  = !out_valid_reg || bus.out_ready;
  assign in_fire   = bus.in_valid && in_ready_c;
  assign last_set  = (set_cnt_reg == SET_W'(PKT_SAMPLES - 1));
  assign fill_sum  = {1'b0, fill_reg} + n_reg;
  assign word_done = in_fire && fill_sum[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mask_ok && out_free) state_next = DATA;
      DATA:    if (in_fire && last_set) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = 1'b0;
    load_ts    = 1'b0;
    case (state_reg)
      IDLE:    load_ts    = mask_ok && out_free;
      DATA:    in_ready_c = out_free;
      default: ;
    endcase
  end

  // Lanes below fill come from the accumulator; the rest take the incoming samples in order.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [1:0] rel;
    assign samp[gi] = bus.in_data[{idx_reg[gi], 4'b0000} +: 16];
    assign rel      = 2'(gi) - fill_reg;
    if (gi < 3) begin : g_acc
      assign lane[gi] = (2'(gi) < fill_reg) ? acc_reg[gi] : samp[rel];
    end else begin : g_top
      assign lane[gi] = samp[rel];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        idx_reg[i] <= 2'd0;
      end
      for (int i = 0; i < 3; i++) begin
        acc_reg[i] <= 16'd0;
      end
      n_reg            <= 3'd0;
      fill_reg         <= 2'd0;
      set_cnt_reg      <= '0;
      out_data_reg     <= 64'd0;
      out_valid_reg    <= 1'b0;
      out_sop_reg      <= 1'b0;
      out_eop_reg      <= 1'b0;
      sample_count_reg <= '0;
      cfg_err_reg      <= 1'b0;
    end else begin
      cfg_err_reg <= (state_reg == IDLE) && !mask_ok;

      if (in_fire) begin
        sample_count_reg <= sample_count_reg + 1'b1;
        set_cnt_reg      <= last_set ? '0 : set_cnt_reg + 1'b1;
        if (fill_sum[2]) begin
          fill_reg <= 2'd0;
        end else begin
          fill_reg <= fill_sum[1:0];
          for (int i = 0; i < 3; i++) begin
            acc_reg[i] <= lane[i];
          end
        end
      end

      if (load_ts) begin
        idx_reg     <= idx_next;
        n_reg       <= n_next;
        fill_reg    <= 2'd0;
        set_cnt_reg <= '0;
      end

      // A new word may replace one that is transferring this cycle.
      if (load_ts) begin
        out_data_reg  <= 64'(sample_count_reg);
        out_valid_reg <= 1'b1;
        out_sop_reg   <= 1'b1;
        out_eop_reg   <= 1'b0;
      end else if (word_done) begin
        out_data_reg  <= {lane[3], lane[2], lane[1], lane[0]};
        out_valid_reg <= 1'b1;
        out_sop_reg   <= 1'b0;
        out_eop_reg   <= last_set;
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
        out_sop_reg   <= 1'b0;
        out_eop_reg   <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sop   = out_sop_reg;
  assign bus.out_eop   = out_eop_reg;
  assign cfg_err       = cfg_err_reg;
  assign sample_count  = sample_count_reg;

endmodule
